// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogram sequencer for the multi-cycle CPU control path. Holds the
//   current microaddress, drives it to an asynchronous microcode ROM, passes
//   the control field of the returned word straight through, and picks the
//   next microaddress with a 4-way branch on two selected condition inputs.
//   Opcodes: BRANCH, CALL, RET, HALT.
//
// Build option:
//   USEQ_STACK_EN  defined   -> return stack implemented (CALL pushes, RET pops,
//                               depth and sticky stack_err live).
//                  undefined -> no stack; CALL acts as BRANCH, RET jumps to
//                               RESET_ADDR, depth/stack_err tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   cond       NCOND condition inputs
//   stall      freeze uaddr/stack/depth/stack_err for this cycle
//   uaddr      registered current microaddress (to ROM)
//   uinstr     microinstruction read at uaddr (same cycle)
//   ctrl       control field of uinstr, combinational
//   halted     current opcode is HALT
//   stack_err  sticky overflow/underflow flag
//   depth      return-stack occupancy
//
// Microinstruction layout, MSB..LSB: OP[1:0] SELA SELB N00 N01 N10 N11 CTRL
module micro_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int NCOND       = 4,
  parameter int CTRL_W      = 22,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int SEL_W = $clog2(NCOND),
  localparam int UW    = 2 + 2*SEL_W + 4*ADDR_W + CTRL_W,
  localparam int DW    = $clog2(STACK_DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCOND-1:0]  cond,
  input  logic              stall,
  output logic [ADDR_W-1:0] uaddr,
  input  logic [UW-1:0]     uinstr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              halted,
  output logic              stack_err,
  output logic [DW-1:0]     depth
);

  typedef enum logic [1:0] {
    OP_BR   = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  localparam logic [ADDR_W-1:0] RA = ADDR_W'(RESET_ADDR);

  op_t                        op;
  logic [SEL_W-1:0]           sela;
  logic [SEL_W-1:0]           selb;
  logic [3:0][ADDR_W-1:0]     nfld;   // [3]=N00 .. [0]=N11
  logic [1:0]                 b;
  logic [ADDR_W-1:0]          tgt;

  assign op     = op_t'(uinstr[UW-1 -: 2]);
  assign sela   = uinstr[UW-3 -: SEL_W];
  assign selb   = uinstr[UW-3-SEL_W -: SEL_W];
  assign nfld   = uinstr[CTRL_W +: 4*ADDR_W];
  assign ctrl   = uinstr[CTRL_W-1:0];
  assign halted = (op == OP_HALT);

  // N00 sits in the top slot, so b=00 selects slot 3: slot index is ~b.
  assign b   = {cond[sela], cond[selb]};
  assign tgt = nfld[~b];

`ifdef USEQ_STACK_EN
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stk;
  logic [DW-1:0]     dep;
  logic              err;
  logic              full;
  logic              empty;
  logic [DW-1:0]     top_idx;
  logic [ADDR_W-1:0] uaddr_inc;

  assign full      = (dep == DW'(STACK_DEPTH));
  assign empty     = (dep == '0);
  assign top_idx   = dep - 1'b1;
  assign uaddr_inc = uaddr + 1'b1;   // wraps mod 2^ADDR_W
  assign depth     = dep;
  assign stack_err = err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uaddr <= RA;
      dep   <= '0;
      err   <= 1'b0;
    end else if (!stall) begin
      case (op)
        OP_BR:   uaddr <= tgt;
        OP_CALL: begin
          uaddr <= tgt;              // jump is taken even when the push is dropped
          if (full) err <= 1'b1;
          else      dep <= dep + 1'b1;
        end
        OP_RET: begin
          if (empty) begin
            uaddr <= RA;
            err   <= 1'b1;
          end else begin
            uaddr <= stk[top_idx[IW-1:0]];
            dep   <= dep - 1'b1;
          end
        end
        OP_HALT: uaddr <= uaddr;
        default: uaddr <= uaddr;
      endcase
    end
  end

  // Stack storage needs no reset: depth alone defines what is live.
  always_ff @(posedge clk) begin
    if (!stall && !reset && op == OP_CALL && !full)
      stk[dep[IW-1:0]] <= uaddr_inc;
  end
`else
  assign depth     = '0;
  assign stack_err = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uaddr <= RA;
    end else if (!stall) begin
      case (op)
        OP_BR,
        OP_CALL: uaddr <= tgt;
        OP_RET:  uaddr <= RA;
        OP_HALT: uaddr <= uaddr;
        default: uaddr <= uaddr;
      endcase
    end
  end
`endif

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the multi-cycle CPU control path. It holds the current microaddress, drives it to an external asynchronous microcode ROM, and passes through the control field of the returned microinstruction. It computes the next microaddress from a 4-way branch on two selectable condition inputs. Over the fixed 16-state, two-condition controller, it adds a wider address, an arbitrary condition count, a stall input, a halt opcode and a subroutine call/return stack.

## Interface
Parameters:
- ADDR_W, 4, microaddress width; microstore depth is 2^ADDR_W
- NCOND, 4, number of condition inputs; must be a power of 2, at least 2; SEL_W = clog2(NCOND)
- CTRL_W, 22, control-field width
- STACK_DEPTH, 4, return-stack entries, at least 1
- RESET_ADDR, 0, microaddress loaded on reset and used on stack underflow
- Derived: UW = 2 + 2*SEL_W + 4*ADDR_W + CTRL_W (44 at defaults)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cond  in  NCOND  condition inputs, e.g. wait_, IR15, AC15, IR14
- stall  in  1  freezes the sequencer for the cycle
- uaddr  out  ADDR_W  registered current microaddress, to the ROM
- uinstr  in  UW  microinstruction at uaddr, valid in the same cycle
- ctrl  out  CTRL_W  uinstr[CTRL_W-1:0], combinational
- halted  out  1  current opcode is HALT
- stack_err  out  1  sticky overflow/underflow flag
- depth  out  clog2(STACK_DEPTH+1)  stack occupancy

## Operation
- Microinstruction fields, MSB to LSB:
  - OP[1:0]
  - SELA[SEL_W]
  - SELB[SEL_W]
  - N00, N01, N10, N11 (each ADDR_W)
  - CTRL[CTRL_W]
- Branch index: b = {cond[SELA], cond[SELB]}. The target T is N00, N01, N10 or N11 for b = 00, 01, 10, 11.
- OP = 00, BRANCH: next = T.
- OP = 01, CALL:
  - Push (uaddr+1) mod 2^ADDR_W, then next = T.
  - If the stack is full: the push is dropped, stack_err is set, and the jump to T is still taken.
- OP = 10, RET:
  - Stack not empty: next = top of stack; pop.
  - Stack empty: next = RESET_ADDR and stack_err is set. SEL fields and N fields are ignored.
- OP = 11, HALT:
  - next = uaddr; halted = 1.
  - Only reset leaves HALT.
- stall = 1: uaddr, stack contents, depth and stack_err all hold; ctrl still follows uinstr. stall takes priority over every OP.
- Stack is LIFO. depth counts 0..STACK_DEPTH.
- Reset values: uaddr = RESET_ADDR, depth = 0, stack_err = 0. ctrl and halted follow the uinstr returned for RESET_ADDR.
- Reset asserted mid-subroutine discards the stack contents.
- Reset asserted mid-stall wins over stall.

## Timing
- One microinstruction per clock. uaddr changes only on a rising clk edge (or asynchronously on reset).
- ROM access is combinational. ctrl is valid in the same cycle as uaddr, after ROM delay, and has zero latency.
- cond is sampled at the rising edge that ends the cycle.
- The next-address decision takes effect at that edge; there are no delay slots.
- CALL at address A followed by RET in the subroutine returns to A+1 on the cycle after RET. Return from address 2^ADDR_W-1 wraps to 0.
- stack_err rises on the edge that commits the faulting CALL/RET and remains high until reset.

## Configuration
- USEQ_STACK_EN defined: CALL and RET behave as above; the stack, depth and stack_err are implemented.
- USEQ_STACK_EN undefined:
  - No stack storage.
  - CALL decodes as BRANCH (next = T).
  - RET decodes as next = RESET_ADDR.
  - depth and stack_err are tied to 0.

## Test plan
- Defaults; reset asserted asynchronously between clock edges -> uaddr = 0 immediately, depth = 0, stack_err = 0.
- BRANCH at 3 with SELA=0, SELB=2, cond=4'b0100 (b=01) and N01=9 -> uaddr = 9 on the next edge; ctrl equals uinstr[21:0] in each cycle.
- CALL at 5 to 12, then RET at 12 -> sequence 5, 12, 6; depth goes 0, 1, 0.
- STACK_DEPTH=2, three nested CALLs -> third CALL still jumps, stack_err = 1, depth = 2. Following RETs return to the two pushed addresses, then a RET on the empty stack -> uaddr = RESET_ADDR.
- HALT at 7 with cond toggling -> uaddr stays 7 and halted = 1 for 10 cycles; reset -> uaddr = 0.
- stall held 3 cycles during a CALL at 4 -> uaddr stays 4 and depth stays 0; on release, uaddr = T and depth = 1. Repeat without USEQ_STACK_EN -> depth stays 0 and the RET goes to 0.
